// File: rtl/frame_write_arbiter.sv
// Two-requester pixel-write arbiter for a 64-pixel red/blue dot matrix.
// Writes go to a back buffer; frame_sync swaps it into the front buffer tear-free.
module frame_write_arbiter (
    input  logic        CLK,
    input  logic        res,
    input  logic        req_a,
    input  logic [5:0]  addr_a,
    input  logic [1:0]  color_a,
    output logic        gnt_a,
    input  logic        req_b,
    input  logic [5:0]  addr_b,
    input  logic [1:0]  color_b,
    output logic        gnt_b,
    input  logic        clr_req,
    output logic        clr_done,
    input  logic        frame_sync,
    output logic [63:0] red_out,
    output logic [63:0] blue_out,
    output logic        busy
);

    typedef enum logic [0:0] {StIdle, StClear} state_e;

    state_e      state;
    logic [63:0] red_bk;
    logic [63:0] blue_bk;
    logic        dirty;
    logic        pending_swap;
    logic        last_b;
    logic [2:0]  row;

    logic        elig_a;
    logic        elig_b;
    logic        grant_a;
    logic        grant_b;
    logic        swap;
    logic [5:0]  wr_addr;
    logic [1:0]  wr_color;

    // A request whose grant is showing this cycle is already serviced.
    assign elig_a = req_a & ~gnt_a;
    assign elig_b = req_b & ~gnt_b;

    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (state == StIdle && !clr_req) begin
            if (elig_a && (!elig_b || last_b)) begin
                grant_a = 1'b1;
            end else if (elig_b) begin
                grant_b = 1'b1;
            end
        end
    end

    assign wr_addr  = grant_a ? addr_a : addr_b;
    assign wr_color = grant_a ? color_a : color_b;
    assign swap     = (state == StIdle) && (frame_sync || pending_swap) && dirty;

    always_ff @(posedge CLK or negedge res) begin
        if (!res) begin
            state        <= StIdle;
            red_bk       <= '0;
            blue_bk      <= '0;
            red_out      <= '0;
            blue_out     <= '0;
            dirty        <= 1'b0;
            pending_swap <= 1'b0;
            last_b       <= 1'b1;
            row          <= 3'd0;
            gnt_a        <= 1'b0;
            gnt_b        <= 1'b0;
            clr_done     <= 1'b0;
            busy         <= 1'b0;
        end else begin
            gnt_a    <= grant_a;
            gnt_b    <= grant_b;
            clr_done <= 1'b0;
            case (state)
                StIdle: begin
                    pending_swap <= 1'b0;
                    // Swap takes the pre-edge back buffer, so a same-edge write waits.
                    if (swap) begin
                        red_out  <= red_bk;
                        blue_out <= blue_bk;
                    end
                    if (grant_a || grant_b) begin
                        red_bk[wr_addr]  <= wr_color[1];
                        blue_bk[wr_addr] <= wr_color[0];
                        last_b           <= grant_b;
                        dirty            <= 1'b1;
                    end else if (swap) begin
                        dirty <= 1'b0;
                    end
                    if (clr_req) begin
                        state <= StClear;
                        busy  <= 1'b1;
                        row   <= 3'd0;
                    end
                end
                StClear: begin
                    red_bk[{row, 3'b000} +: 8]  <= 8'h00;
                    blue_bk[{row, 3'b000} +: 8] <= 8'h00;
                    if (frame_sync) begin
                        pending_swap <= 1'b1;
                    end
                    row <= row + 3'd1;
                    if (row == 3'd7) begin
                        state    <= StIdle;
                        busy     <= 1'b0;
                        clr_done <= 1'b1;
                        dirty    <= 1'b1;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_frame_write_arbiter.sv
// Scoreboard bench: expected grant/clr_done events are queued by the stimulus and
// popped by a monitor; front-buffer contents are checked against hand-computed values.
module tb_frame_write_arbiter;

    localparam int EvA    = 1;
    localparam int EvB    = 2;
    localparam int EvDone = 3;

    logic        clk;
    logic        res;
    logic        req_a, req_b;
    logic [5:0]  addr_a, addr_b;
    logic [1:0]  color_a, color_b;
    logic        gnt_a, gnt_b;
    logic        clr_req, clr_done;
    logic        frame_sync;
    logic [63:0] red_out, blue_out;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int exp_q[$];

    frame_write_arbiter dut (
        .CLK        (clk),
        .res        (res),
        .req_a      (req_a),
        .addr_a     (addr_a),
        .color_a    (color_a),
        .gnt_a      (gnt_a),
        .req_b      (req_b),
        .addr_b     (addr_b),
        .color_b    (color_b),
        .gnt_b      (gnt_b),
        .clr_req    (clr_req),
        .clr_done   (clr_done),
        .frame_sync (frame_sync),
        .red_out    (red_out),
        .blue_out   (blue_out),
        .busy       (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic pop_event(input int got);
        int exp;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL event_order: got event %0d, expected none", got);
        end else begin
            exp = exp_q.pop_front();
            if (exp != got) begin
                errors++;
                $display("FAIL event_order: got event %0d, expected %0d", got, exp);
            end
        end
    endtask

    // Monitor: every output pulse must match the next queued expectation.
    always @(negedge clk) begin
        if (res) begin
            if (gnt_a)    pop_event(EvA);
            if (gnt_b)    pop_event(EvB);
            if (clr_done) pop_event(EvDone);
        end
    end

    task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    task automatic do_write(input bit is_b, input logic [5:0] a, input logic [1:0] c);
        bit got;
        @(negedge clk);
        if (is_b) begin
            req_b = 1'b1; addr_b = a; color_b = c; exp_q.push_back(EvB);
        end else begin
            req_a = 1'b1; addr_a = a; color_a = c; exp_q.push_back(EvA);
        end
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if ((is_b && gnt_b) || (!is_b && gnt_a)) begin
                got = 1'b1;
                break;
            end
        end
        req_a = 1'b0;
        req_b = 1'b0;
        check1("grant_seen", got, 1'b1);
    endtask

    task automatic pulse_sync();
        @(negedge clk);
        frame_sync = 1'b1;
        @(negedge clk);
        frame_sync = 1'b0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        res = 1'b0;
        #1;
        check64("reset_red", red_out, 64'h0);
        check64("reset_blue", blue_out, 64'h0);
        check1("reset_busy", busy, 1'b0);
        @(negedge clk);
        res = 1'b1;
    endtask

    int busy_cnt;

    initial begin
        res = 1'b0; req_a = 1'b0; req_b = 1'b0; addr_a = '0; addr_b = '0;
        color_a = '0; color_b = '0; clr_req = 1'b0; frame_sync = 1'b0;
        #12;
        check1("reset_gnt_a", gnt_a, 1'b0);
        check1("reset_clr_done", clr_done, 1'b0);
        apply_reset();

        // Single write, visible only after the swap.
        do_write(1'b0, 6'd9, 2'b10);
        check64("pre_swap_red", red_out, 64'h0);
        pulse_sync();
        check64("swap_red_9", red_out, 64'h200);
        check64("swap_blue_9", blue_out, 64'h0);

        // Write landing on the frame_sync edge waits for the next swap.
        do_write(1'b0, 6'd3, 2'b11);
        @(negedge clk);
        req_b = 1'b1; addr_b = 6'd5; color_b = 2'b01; frame_sync = 1'b1;
        exp_q.push_back(EvB);
        @(negedge clk);
        frame_sync = 1'b0;
        req_b = 1'b0;
        check64("same_edge_red", red_out, 64'h208);
        check64("same_edge_blue", blue_out, 64'h8);
        pulse_sync();
        check64("next_swap_blue", blue_out, 64'h28);

        // Both requesters held: strict alternation starting with A.
        apply_reset();
        @(negedge clk);
        req_a = 1'b1; addr_a = 6'd10; color_a = 2'b10;
        req_b = 1'b1; addr_b = 6'd20; color_b = 2'b01;
        exp_q.push_back(EvA); exp_q.push_back(EvB);
        exp_q.push_back(EvA); exp_q.push_back(EvB);
        repeat (4) @(negedge clk);
        req_a = 1'b0;
        req_b = 1'b0;
        pulse_sync();
        check64("rr_red", red_out, 64'h400);
        check64("rr_blue", blue_out, 64'h100000);

        // Lone B is granted although the pointer favours A.
        do_write(1'b1, 6'd30, 2'b11);
        pulse_sync();
        check64("lone_b_red", red_out, 64'h4000_0400);
        check64("lone_b_blue", blue_out, 64'h4010_0000);

        // Fill, then clear with frame_sync in CLEAR cycle 3 and a stray clr_req.
        for (int i = 0; i < 64; i++) do_write(1'b0, 6'(i), 2'b11);
        pulse_sync();
        check64("full_red", red_out, {64{1'b1}});
        check64("full_blue", blue_out, {64{1'b1}});
        @(negedge clk);
        clr_req = 1'b1;
        exp_q.push_back(EvDone);
        busy_cnt = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            clr_req    = (k == 2);
            frame_sync = (k == 4);
            if (!busy) break;
            busy_cnt++;
        end
        clr_req = 1'b0;
        frame_sync = 1'b0;
        checks++;
        if (busy_cnt != 8) begin
            errors++;
            $display("FAIL busy_cycles: got %0d, expected 8", busy_cnt);
        end
        check1("clr_done_pulse", clr_done, 1'b1);
        check64("clear_front_held", red_out, {64{1'b1}});
        @(negedge clk);
        check64("clear_swap_red", red_out, 64'h0);
        check64("clear_swap_blue", blue_out, 64'h0);
        check1("clr_done_one_cycle", clr_done, 1'b0);

        // Reset at row 4 of a clear aborts it without clr_done.
        do_write(1'b0, 6'd0, 2'b11);
        pulse_sync();
        check64("pre_abort_red", red_out, 64'h1);
        do_write(1'b0, 6'd1, 2'b11);
        @(negedge clk);
        clr_req = 1'b1;
        @(negedge clk);
        clr_req = 1'b0;
        repeat (4) @(negedge clk);
        check1("abort_busy_before", busy, 1'b1);
        res = 1'b0;
        #1;
        check64("abort_red", red_out, 64'h0);
        check64("abort_blue", blue_out, 64'h0);
        check1("abort_busy", busy, 1'b0);
        check1("abort_clr_done", clr_done, 1'b0);
        @(negedge clk);
        res = 1'b1;
        repeat (12) @(negedge clk);
        check1("post_abort_busy", busy, 1'b0);
        do_write(1'b0, 6'd2, 2'b10);
        pulse_sync();
        check64("post_abort_red", red_out, 64'h4);
        check64("post_abort_blue", blue_out, 64'h0);

        repeat (2) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL missing_events: got %0d outstanding, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/frame_write_arbiter.md
FRAME_WRITE_ARBITER -- requirements
Module: frame_write_arbiter

Interface
REQ-001 SHALL have one clock and reset: reset is asynchronous and active-low.
REQ-002 CLK  input  1  system clock; all state changes on rising edge.
REQ-003 res  input  1  asynchronous active-low reset.
REQ-004 req_a  input  1  pixel-write request, game-move requester A.
REQ-005 addr_a  input  6  pixel index A, row*8+col.
REQ-006 color_a  input  2  pixel colour A: bit1 = red plane, bit0 = blue plane.
REQ-007 gnt_a  output  1  one-cycle grant pulse to A.
REQ-008 req_b, addr_b[5:0], color_b[1:0], gnt_b: the same set for animation requester B.
REQ-009 clr_req  input  1  single-cycle pulse requesting a whole-frame clear.
REQ-010 clr_done  output  1  one-cycle pulse when the clear completes.
REQ-011 frame_sync  input  1  single-cycle pulse at the end of a display scan; the frame swap point.
REQ-012 red_out  output  64  front-buffer red plane to the dot-matrix driver.
REQ-013 blue_out  output  64  front-buffer blue plane to the dot-matrix driver.
REQ-014 busy  output  1  high while in CLEAR.

Function
REQ-015 SHALL hold a back buffer (red_bk, blue_bk, 64b each), a front buffer (red_out, blue_out), a dirty flag, a pending_swap flag and a last-grant pointer.
REQ-016 FSM SHALL have two states, IDLE and CLEAR; reset enters IDLE.
REQ-017 IDLE arbitration: a requester is eligible when its req is high and its gnt is low this cycle.
REQ-018 Eligible requests SHALL be granted at most one per cycle, round-robin; the pointer favours A after reset.
REQ-019 A grant at edge N SHALL write red_bk[addr]=color[1] and blue_bk[addr]=color[0], set dirty, and drive gnt_x=1 during cycle N+1 only.
REQ-020 The requester SHALL hold req/addr/color stable until it sees its grant; the arbiter SHALL ignore req_x in the cycle gnt_x is high, so one request receives exactly one write.
REQ-021 A single eligible requester SHALL be granted regardless of the pointer; the pointer SHALL update to the granted requester.
REQ-022 clr_req in IDLE SHALL enter CLEAR at the next edge and take priority over any same-cycle grant; no write occurs that cycle.
REQ-023 CLEAR SHALL zero one back-buffer row (8 bits per plane) per cycle, rows 0..7, using a 3-bit counter; busy=1; no grants.
REQ-024 After row 7 the FSM SHALL return to IDLE, pulse clr_done for one cycle and set dirty.
REQ-025 clr_req received while in CLEAR SHALL be ignored.
REQ-026 frame_sync in IDLE with dirty=1 SHALL copy the back buffer to the front buffer at that edge and clear dirty.
REQ-027 frame_sync with dirty=0 SHALL leave the front buffer unchanged.
REQ-028 A write committed at the same edge as a swap SHALL NOT appear in that swap; dirty SHALL remain set so the write goes out at the next frame_sync.
REQ-029 frame_sync during CLEAR SHALL set pending_swap; the swap SHALL occur on the first IDLE cycle after CLEAR, then pending_swap clears.
REQ-030 The front buffer SHALL change only at swap edges, giving tear-free display.
REQ-031 Swap latency SHALL be 0 cycles: front buffer valid the cycle after the frame_sync edge.

Reset
REQ-032 Asserting res (low) SHALL immediately force: all buffers = 0; gnt_a, gnt_b, clr_done, busy = 0; dirty, pending_swap = 0; pointer = B-last (so A wins first); FSM = IDLE; row counter = 0.
REQ-033 Reset during CLEAR SHALL abort the clear with no clr_done pulse.

Verification
REQ-034 Request A, addr 9, colour 2'b10, then frame_sync -> gnt_a pulses 1 cycle; red_out[9]=1, blue_out[9]=0 after the swap; all other bits 0.
REQ-035 req_a and req_b held continuously after reset -> grants alternate A, B, A, B; each gnt lasts 1 cycle; no double write.
REQ-036 Write committed on the frame_sync edge -> the front buffer does not change for that write; it appears after the next frame_sync.
REQ-037 clr_req with a full back buffer, frame_sync at CLEAR cycle 3 -> busy high for 8 cycles, then clr_done pulses; red_out = blue_out = 0 on the following cycle.
REQ-038 res low mid-CLEAR (row 4) -> all outputs 0 immediately; no clr_done; the FSM is in IDLE when res is released.
